unified_mem_arbiter: RTL

- Shares one single-ported unified instruction/data memory between the instruction-fetch requester and the load/store requester of the RISC-V core.
- Sits between the core's fetch/memory stages and the memory macro, and sequences every memory access.
- Allows exactly one outstanding access at a time.
- Data accesses have priority over fetch, with an anti-starvation counter that forces a fetch grant.

---
 rtl/unified_mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: single-outstanding arbiter for a shared I/D memory, data first with fetch anti-starvation; MEM_ARB_PERF_EN adds stall counters.
// Grant is combinational in IDLE, rvalid follows MEM_LAT+1 cycles later; requests are held until gnt and ignored while busy.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]       if_stall_cnt,
    output logic [15:0]       d_stall_cnt
`endif
);

    localparam logic [2:0] LAT        = 3'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state_q;
    logic [2:0]        lat_cnt_q;
    logic [3:0]        starve_q;
    logic [3:0]        starve_d;
    logic              owner_data_q;
    logic              store_q;
    logic              if_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic idle;
    logic fetch_win;

    assign idle = (state_q == S_IDLE);

    // Fetch wins only when data is absent or fetch has been denied STARVE_MAX times in a row.
    assign fetch_win = if_req & (~d_req | (starve_q == STARVE_LIM));
    assign if_gnt    = idle & fetch_win;
    assign d_gnt     = idle & d_req & ~fetch_win;

    assign mem_en    = if_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
    assign mem_wdata = d_gnt ? d_wdata : '0;

    assign busy      = ~idle;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    always_comb begin
        starve_d = starve_q;
        if (if_gnt) begin
            starve_d = '0;
        end else if (idle && if_req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lat_cnt_q    <= '0;
            starve_q     <= '0;
            owner_data_q <= 1'b0;
            store_q      <= 1'b0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            starve_q    <= starve_d;
            case (state_q)
                S_IDLE: begin
                    if (mem_en) begin
                        state_q      <= S_WAIT;
                        lat_cnt_q    <= 3'd1;
                        owner_data_q <= d_gnt;
                        store_q      <= d_gnt & d_we;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt_q < LAT) begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end else begin
                        // mem_rdata is valid in this cycle; the pulse appears the cycle after.
                        state_q   <= S_IDLE;
                        lat_cnt_q <= '0;
                        if (owner_data_q) begin
                            d_rvalid_q <= 1'b1;
                            if (!store_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= mem_rdata;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [15:0] if_stall_q;
    logic [15:0] d_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_stall_q <= '0;
            d_stall_q  <= '0;
        end else begin
            if (if_req && !if_gnt && (if_stall_q != 16'hFFFF)) begin
                if_stall_q <= if_stall_q + 16'd1;
            end
            if (d_req && !d_gnt && (d_stall_q != 16'hFFFF)) begin
                d_stall_q <= d_stall_q + 16'd1;
            end
        end
    end

    assign if_stall_cnt = if_stall_q;
    assign d_stall_cnt  = d_stall_q;
`endif

endmodule
